gate_vector_sequencer: RTL and testbench
========================================

Name: gate_vector_sequencer

Overview:
- Self-checking controller that sequences a 3-input, 2-output gate datapath (inputs a, b, d; outputs out1, out2) through all 2^VEC_W input vectors in ascending order.
- For each vector it drives the gate inputs, waits a programmable settle time, samples both outputs and compares them against a truth table supplied by the requester.
- It reports the error count, the first failing vector and a pass flag.
- It sits between a test/config master and the gate block, replacing hand-written stimulus sequences.

Parameters:
- VEC_W, 3, number of gate inputs; number of vectors = 2^VEC_W. Default mapping: a=vec[2], b=vec[1], d=vec[0].
- SETTLE_CYCLES, 2, cycles each vector is held before sampling. Legal range 1..255; 0 is illegal.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
- abort  in  1  terminates a running sweep.
- exp_tbl  in  2*2^VEC_W  expected outputs; bits [2v+1:2v] = {out2,out1} expected for vector v.
- gate_out1  in  1  gate output out1.
- gate_out2  in  1  gate output out2.
- gate_a  out  1  gate input a (registered).
- gate_b  out  1  gate input b (registered).
- gate_d  out  1  gate input d (registered).
- busy  out  1  high in SETTLE and CHECK.
- done  out  1  one-cycle pulse at normal sweep completion.
- pass  out  1  1 when the last completed sweep had zero mismatches.
- err_count  out  VEC_W+1  mismatch count for the current/last sweep.
- fail_valid  out  1  at least one mismatch seen this sweep.
- first_fail_vec  out  VEC_W  index of the first mismatching vector.

Behaviour:
- Reset (async, immediate): state=IDLE, vec=0, settle cnt=0, gate_a/b/d=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0, latched table=0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1 at edge E0:
  - latch exp_tbl; clear err_count, fail_valid, first_fail_vec, pass.
  - vec=0, drive gate inputs from vec, cnt=0 -> SETTLE.
- exp_tbl changes after E0 do not affect the running sweep.
- SETTLE: cnt increments each edge; at the edge where cnt==SETTLE_CYCLES-1 -> CHECK. Gate inputs are held stable.
- CHECK (one cycle): compare {gate_out2,gate_out1} with the latched entry for vec.
  - On mismatch: err_count+1; if fail_valid==0, set fail_valid=1 and first_fail_vec=vec.
  - If vec==2^VEC_W-1 -> DONE; else vec+1, drive new inputs, cnt=0 -> SETTLE.
- Each vector occupies SETTLE_CYCLES+1 edges. The final CHECK edge is E(2^VEC_W*(SETTLE_CYCLES+1)): 24 for the defaults.
- DONE (one cycle): done=1 and pass=(err_count==0) become visible in the cycle after the final CHECK edge; next edge -> IDLE, done=0.
- pass, err_count, fail_valid and first_fail_vec hold until the next accepted start or reset.
- start while busy or in DONE: ignored, with no effect on the sweep or results.
- abort in SETTLE/CHECK: next edge -> IDLE, gate inputs=0, done stays 0, pass=0. err_count/first_fail_vec keep their partial values, including any mismatch counted on that CHECK edge.
- start and abort together in IDLE: abort wins, start is ignored.
- The vector counter does not wrap; err_count max 2^VEC_W fits VEC_W+1 bits, so no saturation is needed.
- No combinational path from any input to any output.

Test Plan:
- Reset, default params, exp_tbl matching the gate, pulse start -> done high exactly 24 cycles after the start edge; pass=1, err_count=0, fail_valid=0; gate_a/b/d step through 000..111, each held 3 cycles.
- exp_tbl with only entries 5 and 6 flipped -> err_count=2, fail_valid=1, first_fail_vec=5, pass=0.
- exp_tbl bitwise-inverted -> err_count=8, first_fail_vec=0, pass=0.
- start re-pulsed at cycles 4 and 10 of a sweep -> done still at cycle 24, exactly one done pulse; change exp_tbl mid-sweep -> results unchanged.
- abort during vector 3 -> IDLE next cycle, done never asserted, pass=0, gate inputs=0; a new start then runs a full clean sweep.
- rst asserted asynchronously mid-SETTLE -> all outputs zero before the next clock edge. Separate run with SETTLE_CYCLES=1 -> done 16 cycles after the start edge.

Source files
------------

// File: rtl/gate_vector_sequencer.sv
// rtl/gate_vector_sequencer.sv - sweeps all gate input vectors and checks outputs against a truth table
module gate_vector_sequencer #(
  parameter int VEC_W         = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [2*(2**VEC_W)-1:0]   exp_tbl,
  input  logic                      gate_out1,
  input  logic                      gate_out2,
  output logic                      gate_a,
  output logic                      gate_b,
  output logic                      gate_d,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [VEC_W:0]            err_count,
  output logic                      fail_valid,
  output logic [VEC_W-1:0]          first_fail_vec
);

  localparam int         NVEC        = 2**VEC_W;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t              state, state_nxt;
  logic [VEC_W-1:0]    vec;
  logic [7:0]          cnt;
  logic [2*NVEC-1:0]   tbl_q;
  logic                last_vec;
  logic                mismatch;
  logic [VEC_W:0]      err_nxt;
  logic                accept;

  assign accept   = (state == IDLE) && start && !abort;
  assign last_vec = (vec == VEC_W'(NVEC - 1));
  assign mismatch = ({gate_out2, gate_out1} != {tbl_q[{vec, 1'b1}], tbl_q[{vec, 1'b0}]});
  assign err_nxt  = err_count + (VEC_W+1)'(mismatch);

  // The gate is driven straight from the registered vector counter.
  assign gate_a = vec[2];
  assign gate_b = vec[1];
  assign gate_d = vec[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETTLE;
      SETTLE:  if (abort) state_nxt = IDLE;
               else if (cnt == SETTLE_LAST) state_nxt = CHECK;
      CHECK:   if (abort) state_nxt = IDLE;
               else if (last_vec) state_nxt = DONE;
               else state_nxt = SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SETTLE) || (state == CHECK);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec            <= '0;
      cnt            <= '0;
      tbl_q          <= '0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          tbl_q          <= exp_tbl;
          err_count      <= '0;
          fail_valid     <= 1'b0;
          first_fail_vec <= '0;
          pass           <= 1'b0;
          vec            <= '0;
          cnt            <= '0;
        end
        SETTLE: begin
          if (abort) begin
            vec  <= '0;
            pass <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CHECK: begin
          // A mismatch on this edge counts even when the sweep is being aborted.
          err_count <= err_nxt;
          if (mismatch && !fail_valid) begin
            fail_valid     <= 1'b1;
            first_fail_vec <= vec;
          end
          if (abort) begin
            vec  <= '0;
            pass <= 1'b0;
          end else if (last_vec) begin
            pass <= (err_nxt == '0);
          end else begin
            vec <= vec + VEC_W'(1);
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb/tb_gate_vector_sequencer.sv - randomized self-checking bench for gate_vector_sequencer
module tb_gate_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] exp_tbl, gtbl;

  logic       a0, b0, d0, o1_0, o2_0, busy0, done0, pass0, fv0;
  logic [3:0] err0;
  logic [2:0] ffv0;
  logic       a1, b1, d1, o1_1, o2_1, busy1, done1, pass1, fv1;
  logic [3:0] err1;
  logic [2:0] ffv1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural gate: arbitrary truth table indexed by {a,b,d}.
  always_comb begin
    o2_0 = gtbl[{a0, b0, d0, 1'b1}];
    o1_0 = gtbl[{a0, b0, d0, 1'b0}];
    o2_1 = gtbl[{a1, b1, d1, 1'b1}];
    o1_1 = gtbl[{a1, b1, d1, 1'b0}];
  end

  gate_vector_sequencer #(.VEC_W(3), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tbl(exp_tbl),
    .gate_out1(o1_0), .gate_out2(o2_0), .gate_a(a0), .gate_b(b0), .gate_d(d0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .first_fail_vec(ffv0));

  gate_vector_sequencer #(.VEC_W(3), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tbl(exp_tbl),
    .gate_out1(o1_1), .gate_out2(o2_1), .gate_a(a1), .gate_b(b1), .gate_d(d1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail_vec(ffv1));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_errs(input logic [15:0] t, input int lim);
    int n = 0;
    for (int v = 0; v < lim; v++)
      if (gtbl[2*v +: 2] != t[2*v +: 2]) n++;
    return n;
  endfunction

  function automatic int model_first(input logic [15:0] t, input int lim);
    for (int v = 0; v < lim; v++)
      if (gtbl[2*v +: 2] != t[2*v +: 2]) return v;
    return 0;
  endfunction

  // Runs one sweep on both instances. abort_at = edge index at which abort is sampled (0 = none).
  task automatic sweep(input logic [15:0] tbl, input int abort_at, input bit repulse, input bit chg);
    int  dcnt0 = 0, dcyc0 = -1, dcnt1 = 0, dcyc1 = -1;
    bit  ab0, ab1, abd0, abd1;
    int  lim0, lim1, e0, e1;
    abd0 = (abort_at > 0) && (abort_at <= 24);
    abd1 = (abort_at > 0) && (abort_at <= 16);
    @(negedge clk);
    exp_tbl = tbl;
    start   = 1'b1;
    abort   = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      ab0 = abd0 && (k >= abort_at);
      ab1 = abd1 && (k >= abort_at);
      check("vec0", {a0, b0, d0}, ab0 ? 0 : ((k / 3) > 7 ? 7 : k / 3));
      check("busy0", busy0, int'(!ab0 && k < 24));
      check("vec1", {a1, b1, d1}, ab1 ? 0 : ((k / 2) > 7 ? 7 : k / 2));
      check("busy1", busy1, int'(!ab1 && k < 16));
      if (done0) begin dcnt0++; dcyc0 = k; end
      if (done1) begin dcnt1++; dcyc1 = k; end
      start = repulse && (k + 1 == 4 || k + 1 == 10);
      abort = (k + 1 == abort_at);
      if (chg && k + 1 == 5) exp_tbl = ~tbl;
    end
    start = 1'b0;
    abort = 1'b0;
    lim0 = abd0 ? abort_at / 3 : 8;
    lim1 = abd1 ? abort_at / 2 : 8;
    e0 = model_errs(tbl, lim0);
    e1 = model_errs(tbl, lim1);
    check("err0", err0, e0);
    check("fail_valid0", fv0, int'(e0 > 0));
    check("first_fail0", ffv0, model_first(tbl, lim0));
    check("pass0", pass0, int'(!abd0 && e0 == 0));
    check("done_cnt0", dcnt0, abd0 ? 0 : 1);
    check("done_cyc0", dcyc0, abd0 ? -1 : 24);
    check("err1", err1, e1);
    check("fail_valid1", fv1, int'(e1 > 0));
    check("first_fail1", ffv1, model_first(tbl, lim1));
    check("pass1", pass1, int'(!abd1 && e1 == 0));
    check("done_cnt1", dcnt1, abd1 ? 0 : 1);
    check("done_cyc1", dcyc1, abd1 ? -1 : 16);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gate0"}, {a0, b0, d0}, 0);
    check({tag, "_busy0"}, busy0, 0);
    check({tag, "_done0"}, done0, 0);
    check({tag, "_pass0"}, pass0, 0);
    check({tag, "_err0"}, err0, 0);
    check({tag, "_fv0"}, fv0, 0);
    check({tag, "_ffv0"}, ffv0, 0);
    check({tag, "_gate1"}, {a1, b1, d1}, 0);
    check({tag, "_err1"}, err1, 0);
    check({tag, "_busy1"}, busy1, 0);
  endtask

  task automatic reset_mid_sweep();
    @(negedge clk);
    exp_tbl = ~gtbl;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_err0", err0, model_errs(~gtbl, 2));
    check("pre_rst_busy0", busy0, 1);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] flips;
    int          ab;
    bit          rep;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    exp_tbl = '0;
    gtbl    = 16'($urandom);
    #12 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    sweep(gtbl, 0, 1'b0, 1'b0);
    sweep(gtbl ^ 16'h3C00, 0, 1'b0, 1'b0);
    sweep(~gtbl, 0, 1'b0, 1'b0);
    sweep(gtbl, 0, 1'b1, 1'b1);
    sweep(gtbl ^ 16'h0030, 10, 1'b0, 1'b0);
    sweep(gtbl, 0, 1'b0, 1'b0);
    reset_mid_sweep();
    sweep(gtbl, 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      gtbl  = 16'($urandom);
      flips = 16'($urandom) & 16'($urandom) & 16'($urandom);
      ab    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 26)) : 0;
      rep   = (ab == 0) && ($urandom_range(0, 1) == 1);
      sweep(gtbl ^ flips, ab, rep, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
